mmio_periph: RTL
================

Name: mmio_periph

Overview:
Responder end of the core's MMIO bus; the LSU is the initiator.
- Decodes the 4 KB page of each access, merges partial stores itself (the LSU passes store data unshifted), and holds the board output registers.
- Synchronises the switch inputs and implements timer0 (prescaled counter, compare, interrupt).
- Read data is returned as an aligned word; the LSU extracts bytes and halves.

Parameters:
PRESC_DIV, 50, timer0 prescaler divide ratio, in clock cycles per count tick (>=1).
SW_W, 18, switch input width.
LEDR_W, 18, red LED register width.
LEDG_W, 9, green LED register width.

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  reset; asynchronous, active-low.
i_mmio_we  in  1  write strobe, 1 cycle per store.
i_mmio_addr  in  32  byte address.
i_mmio_wdata  in  32  unshifted store data.
i_mmio_size  in  3  store size: 0 byte, 1 half, 2 word.
o_mmio_rdata  out  32  aligned read word, combinational from i_mmio_addr.
i_sw  in  SW_W  raw switches, asynchronous.
o_ledr  out  LEDR_W  red LEDs.
o_ledg  out  LEDG_W  green LEDs.
o_hex_lo  out  32  HEX3..0, one byte per digit; bits 6:0 of each byte are segments.
o_hex_hi  out  32  HEX7..4, same layout.
o_lcd  out  32  LCD control/data word.
o_timer_irq  out  1  timer0 interrupt, level.

Behaviour:
Page decode
- Page is i_mmio_addr & 32'hFFFF_F000, compared against the shared macros BASE_LEDR, BASE_LEDG, BASE_HEX_LO, BASE_HEX_HI, BASE_LCD, BASE_TIMER0, BASE_SW.
- Single-register pages decode word offset 0x000 only. Any other offset, and any unmapped page, reads 0 and ignores writes.

Write merge, at page register word R
- Byte (size 0): lane addr[1:0] <= wdata[7:0].
- Half (size 1):
  - addr[1:0]=0 → lanes 1:0 <= wdata[15:0].
  - addr[1:0]=2 → lanes 3:2 <= wdata[15:0].
  - addr[1:0]=1 → lanes 2:1 <= wdata[15:0].
  - addr[1:0]=3 → lane 3 <= wdata[7:0] only.
- Word (size 2 or any other value): whole word; addr[1:0] ignored.
- Register updates on the clock edge with we. Narrow registers keep their low bits only; unused upper read bits return 0.

Registers
- LEDR, LEDG, HEX_LO, HEX_HI, LCD drive their outputs directly from the flops (1-cycle write-to-output latency).
- SW page: read-only. i_sw passes through a 2-flop synchroniser; a read returns the zero-extended synchronised value. An input change is visible 2 edges later. Writes are ignored.

Timer0 page
- 0x0 CTRL[2:0]: bit0 enable, bit1 auto-reload, bit2 irq enable.
- 0x4 COUNT[31:0].
- 0x8 CMP[31:0].
- 0xC STATUS[0]: match flag, write-1-to-clear.
- Prescaler counts 0..PRESC_DIV-1 while enable=1. A tick occurs when it wraps. While enable=0 the prescaler is held at 0.
- On a tick, if COUNT==CMP: STATUS.match <= 1 and COUNT <= auto-reload ? 0 : COUNT+1. Otherwise COUNT <= COUNT+1, wrapping 0xFFFF_FFFF → 0.
- A CPU write to COUNT in the same cycle as a tick wins.
- A CPU write to CTRL that clears enable also zeroes the prescaler.
- A match set and a W1C clear in the same cycle: set wins.
- o_timer_irq = STATUS.match & CTRL.irq_en (combinational).

Reset
- i_rst_n low clears asynchronously, regardless of any access in flight: all registers, the prescaler, the synchroniser flops, CTRL, COUNT, CMP (0x0000_0000), and STATUS.
- All outputs are 0 during reset.
- The first write is accepted on the first rising edge after release.

Optional Feature:
MMIO_TIMER0_EN
- Defined: the timer0 page is implemented as above.
- Undefined: no timer logic is instantiated; the BASE_TIMER0 page reads 0, writes are ignored, and o_timer_irq is tied to 0. PRESC_DIV is then unused.

Test Plan:
1. Byte merge: SW 0x11223344 to BASE_HEX_LO, then SB wdata=0xAA at +1 → o_hex_lo=0x1122AA44; SH wdata=0xBEEF at +2 → 0xBEEFAA44; read BASE_HEX_LO → 0xBEEFAA44.
2. Width and unmapped: SW 0xFFFF_FFFF to BASE_LEDR → o_ledr=18'h3FFFF, read 0x0003FFFF. SW to BASE_LEDR+4 → no change, read 0. Read of an unmapped page → 0.
3. Switch sync: i_sw 0→0x2A5A5 → BASE_SW read is 0 for the next edge, and 0x0002A5A5 after the 2nd edge; a write to SW leaves the read value unchanged.
4. Timer auto-reload (PRESC_DIV=4): CMP=3, CTRL=0x7 → COUNT steps 1,2,3 every 4 cycles; on the 4th tick STATUS=1, o_timer_irq=1, COUNT=0. SW 1 to STATUS → irq drops the next cycle.
5. Timer edges: write COUNT=5 on a tick cycle → COUNT=5. With auto-reload off and COUNT=0xFFFF_FFFF, CMP=2 → next tick COUNT=0. W1C coincident with match → STATUS stays 1.
6. Reset mid-operation: timer running, LEDR=0x155, pull i_rst_n low between edges → all outputs, COUNT and STATUS read 0 immediately; build without MMIO_TIMER0_EN → timer page reads 0, o_timer_irq=0.

Source files
------------

// File: rtl/mmio_periph.sv
// mmio_periph: MMIO responder for the board LEDs, HEX digits, LCD word, switches and timer0.
// Define MMIO_TIMER0_EN to build the timer0 page; without it that page reads 0 and o_timer_irq is 0.
`ifndef BASE_LEDR
`define BASE_LEDR   32'h1000_0000
`endif
`ifndef BASE_LEDG
`define BASE_LEDG   32'h1000_1000
`endif
`ifndef BASE_HEX_LO
`define BASE_HEX_LO 32'h1000_2000
`endif
`ifndef BASE_HEX_HI
`define BASE_HEX_HI 32'h1000_3000
`endif
`ifndef BASE_LCD
`define BASE_LCD    32'h1000_4000
`endif
`ifndef BASE_TIMER0
`define BASE_TIMER0 32'h1000_5000
`endif
`ifndef BASE_SW
`define BASE_SW     32'h1001_0000
`endif

module mmio_periph #(
   parameter int PRESC_DIV = 50,
   parameter int SW_W      = 18,
   parameter int LEDR_W    = 18,
   parameter int LEDG_W    = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_mmio_we,
   input  logic [31:0]       i_mmio_addr,
   input  logic [31:0]       i_mmio_wdata,
   input  logic [2:0]        i_mmio_size,
   output logic [31:0]       o_mmio_rdata,
   input  logic [SW_W-1:0]   i_sw,
   output logic [LEDR_W-1:0] o_ledr,
   output logic [LEDG_W-1:0] o_ledg,
   output logic [31:0]       o_hex_lo,
   output logic [31:0]       o_hex_hi,
   output logic [31:0]       o_lcd,
   output logic              o_timer_irq
);

   if (PRESC_DIV < 1) begin : g_presc_check
      $error("mmio_periph: PRESC_DIV must be >= 1");
   end

   // Store data arrives unshifted; place it into the addressed lanes of the old word.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [2:0] sz, input logic [1:0] ln);
      logic [31:0] m;
      m = old;
      case (sz)
         3'd0: m[{ln, 3'b000} +: 8] = wd[7:0];
         3'd1: begin
            case (ln)
               2'd0:    m[15:0]  = wd[15:0];
               2'd1:    m[23:8]  = wd[15:0];
               2'd2:    m[31:16] = wd[15:0];
               default: m[31:24] = wd[7:0];
            endcase
         end
         default: m = wd;
      endcase
      return m;
   endfunction

   logic [31:0]       wd;
   logic [2:0]        sz;
   logic [1:0]        ln;
   logic [31:0]       page;
   logic              off0;
   logic              sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw;
   logic [LEDR_W-1:0] ledr_q;
   logic [LEDG_W-1:0] ledg_q;
   logic [31:0]       hex_lo_q, hex_hi_q, lcd_q;
   logic [SW_W-1:0]   sw_meta, sw_sync;

   assign wd   = i_mmio_wdata;
   assign sz   = i_mmio_size;
   assign ln   = i_mmio_addr[1:0];
   assign page = i_mmio_addr & 32'hFFFF_F000;
   assign off0 = (i_mmio_addr[11:2] == 10'd0);

   assign sel_ledr   = (page == `BASE_LEDR)   && off0;
   assign sel_ledg   = (page == `BASE_LEDG)   && off0;
   assign sel_hex_lo = (page == `BASE_HEX_LO) && off0;
   assign sel_hex_hi = (page == `BASE_HEX_HI) && off0;
   assign sel_lcd    = (page == `BASE_LCD)    && off0;
   assign sel_sw     = (page == `BASE_SW)     && off0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ledr_q   <= '0;
         ledg_q   <= '0;
         hex_lo_q <= '0;
         hex_hi_q <= '0;
         lcd_q    <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         sw_meta <= i_sw;
         sw_sync <= sw_meta;
         if (i_mmio_we && sel_ledr)   ledr_q   <= LEDR_W'(merge(32'(ledr_q), wd, sz, ln));
         if (i_mmio_we && sel_ledg)   ledg_q   <= LEDG_W'(merge(32'(ledg_q), wd, sz, ln));
         if (i_mmio_we && sel_hex_lo) hex_lo_q <= merge(hex_lo_q, wd, sz, ln);
         if (i_mmio_we && sel_hex_hi) hex_hi_q <= merge(hex_hi_q, wd, sz, ln);
         if (i_mmio_we && sel_lcd)    lcd_q    <= merge(lcd_q, wd, sz, ln);
      end
   end

   assign o_ledr   = ledr_q;
   assign o_ledg   = ledg_q;
   assign o_hex_lo = hex_lo_q;
   assign o_hex_hi = hex_hi_q;
   assign o_lcd    = lcd_q;

`ifdef MMIO_TIMER0_EN
   localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

   logic [PW-1:0] presc_q;
   logic [2:0]    ctrl_q;
   logic [31:0]   count_q, cmp_q;
   logic          match_q;
   logic          sel_tmr, wr_ctrl, wr_count, wr_cmp, wr_status;
   logic [2:0]    ctrl_wr;
   logic          status_wr;
   logic          tick, hit;
   logic [31:0]   tmr_rdata;

   assign sel_tmr   = (page == `BASE_TIMER0) && (i_mmio_addr[11:4] == 8'd0);
   assign wr_ctrl   = i_mmio_we && sel_tmr && (i_mmio_addr[3:2] == 2'd0);
   assign wr_count  = i_mmio_we && sel_tmr && (i_mmio_addr[3:2] == 2'd1);
   assign wr_cmp    = i_mmio_we && sel_tmr && (i_mmio_addr[3:2] == 2'd2);
   assign wr_status = i_mmio_we && sel_tmr && (i_mmio_addr[3:2] == 2'd3);
   assign ctrl_wr   = 3'(merge({29'd0, ctrl_q}, wd, sz, ln));
   // Merging into zero isolates the bit the store actually wrote to lane 0.
   assign status_wr = 1'(merge(32'd0, wd, sz, ln));
   assign tick      = ctrl_q[0] && (presc_q == PW'(PRESC_DIV - 1));
   assign hit       = tick && (count_q == cmp_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q <= '0;
         ctrl_q  <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         match_q <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_q <= ctrl_wr;
         if (wr_cmp)  cmp_q  <= merge(cmp_q, wd, sz, ln);
         if (!ctrl_q[0] || tick || (wr_ctrl && !ctrl_wr[0])) presc_q <= '0;
         else                                                 presc_q <= presc_q + PW'(1);
         if (wr_count)  count_q <= merge(count_q, wd, sz, ln);
         else if (tick) count_q <= (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
         if (hit)                           match_q <= 1'b1;
         else if (wr_status && status_wr)   match_q <= 1'b0;
      end
   end

   always_comb begin
      case (i_mmio_addr[3:2])
         2'd0:    tmr_rdata = {29'd0, ctrl_q};
         2'd1:    tmr_rdata = count_q;
         2'd2:    tmr_rdata = cmp_q;
         default: tmr_rdata = {31'd0, match_q};
      endcase
   end

   assign o_timer_irq = match_q & ctrl_q[2];
`else
   assign o_timer_irq = 1'b0;
`endif

   always_comb begin
      o_mmio_rdata = 32'd0;
      if (sel_ledr)   o_mmio_rdata = 32'(ledr_q);
      if (sel_ledg)   o_mmio_rdata = 32'(ledg_q);
      if (sel_hex_lo) o_mmio_rdata = hex_lo_q;
      if (sel_hex_hi) o_mmio_rdata = hex_hi_q;
      if (sel_lcd)    o_mmio_rdata = lcd_q;
      if (sel_sw)     o_mmio_rdata = 32'(sw_sync);
`ifdef MMIO_TIMER0_EN
      if (sel_tmr)    o_mmio_rdata = tmr_rdata;
`endif
   end

endmodule
